data_mem_copy_engine: RTL

- Bus initiator for the single-port data memory, which has synchronous write, asynchronous read and sequential init on reset.
- Copies a block of LEN words from SRC to DST, one word at a time, by driving the memory's W/ADDR/DATA_WR and sampling DATA_RD.
- Sits beside the core. An external mux gives it the memory port while busy=1.

---
 rtl/data_mem_copy_pkg.sv | 14 +
 rtl/data_mem_copy_engine.sv | 112 +++++++++++
 2 files changed

// File: rtl/data_mem_copy_pkg.sv
// rtl/data_mem_copy_pkg.sv - shared types and default widths for the data memory copy engine
package data_mem_copy_pkg;

    localparam int DMC_DATA_SIZE = 8;
    localparam int DMC_ADDR_SIZE = 5;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } copy_state_t;

endpackage

// File: rtl/data_mem_copy_engine.sv
// rtl/data_mem_copy_engine.sv - word-by-word block copier on the data memory port (option: DATA_MEM_COPY_CHECKSUM_EN)
module data_mem_copy_engine
    import data_mem_copy_pkg::*;
#(
    parameter int DATA_SIZE = DMC_DATA_SIZE,
    parameter int ADDR_SIZE = DMC_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] src_addr,
    input  logic [ADDR_SIZE-1:0] dst_addr,
    input  logic [ADDR_SIZE:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_w,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
`ifdef DATA_MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_SIZE-1:0] checksum
`endif
);

    localparam logic [ADDR_SIZE:0] IDX_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

    copy_state_t            state_q;
    copy_state_t            state_d;
    logic [ADDR_SIZE-1:0]   src_q;
    logic [ADDR_SIZE-1:0]   dst_q;
    logic [ADDR_SIZE:0]     len_q;
    logic [ADDR_SIZE:0]     idx_q;
    logic [DATA_SIZE-1:0]   buf_q;
    logic [ADDR_SIZE-1:0]   idx_lo;
    logic                   last_word;

    // Addresses wrap silently: only the low ADDR_SIZE bits of idx take part.
    assign idx_lo    = idx_q[ADDR_SIZE-1:0];
    assign last_word = (idx_q + IDX_ONE) == len_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? DONE : READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= len;
                        idx_q <= '0;
                    end
                end
                READ:    buf_q <= mem_rdata;
                WRITE:   idx_q <= idx_q + IDX_ONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        mem_w     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            READ:  mem_addr = src_q + idx_lo;
            WRITE: begin
                mem_addr  = dst_q + idx_lo;
                mem_wdata = buf_q;
                mem_w     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DATA_MEM_COPY_CHECKSUM_EN
    logic [DATA_SIZE-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sum_q <= '0;
        end else if (state_q == IDLE && start) begin
            sum_q <= '0;
        end else if (state_q == WRITE) begin
            sum_q <= sum_q + buf_q;
        end
    end

    assign checksum = sum_q;
`endif

endmodule
